// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-requester memory arbiter: default memory
// widths, FSM state encodings and memory_unit function codes.
package mem_arbiter_pkg;

  localparam int MEM_ADDR_WIDTH = 16;
  localparam int MEM_DATA_WIDTH = 68;

  typedef enum logic [2:0] {
    MEM_ARB_IDLE      = 3'd0,
    MEM_ARB_ISSUE     = 3'd1,
    MEM_ARB_WAIT_BUSY = 3'd2,
    MEM_ARB_WAIT_DONE = 3'd3,
    MEM_ARB_RESPOND   = 3'd4
  } mem_arb_state_e;

  localparam logic [1:0] GET_CONTENTS = 2'b00;
  localparam logic [1:0] SET_CONTENTS = 2'b01;
  localparam logic [1:0] GET_NEXT     = 2'b10;
  localparam logic [1:0] CLEAR_ENTRY  = 2'b11;

  // A command is in flight in every state except IDLE.
  function automatic logic arb_busy(input mem_arb_state_e s);
    return (s != MEM_ARB_IDLE);
  endfunction

endpackage

// File: rtl/mem_arbiter_pick.sv
// Combinational 2-way request selector.
// Build option: MEM_ARB_FIXED_PRIO_EN makes requester 0 win every tie;
// otherwise ties go to the requester that did not win last time.
module mem_arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       rr_last,
  output logic [1:0] grant,
  output logic       gnt_id
);

`ifdef MEM_ARB_FIXED_PRIO_EN
  logic unused_rr_last;
  assign unused_rr_last = rr_last;
`endif

  // Pick one eligible requester; a tie resolves by priority mode.
  always_comb begin
    grant  = 2'b00;
    gnt_id = 1'b0;
    case (valid)
      2'b01: begin
        grant  = 2'b01;
        gnt_id = 1'b0;
      end
      2'b10: begin
        grant  = 2'b10;
        gnt_id = 1'b1;
      end
      2'b11: begin
`ifdef MEM_ARB_FIXED_PRIO_EN
        gnt_id = 1'b0;
`else
        gnt_id = ~rr_last;
`endif
        grant  = gnt_id ? 2'b10 : 2'b01;
      end
      default: begin
        grant  = 2'b00;
        gnt_id = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single memory_unit port.
// Serialises commands, runs the execute/is_ready handshake for the granted
// requester and returns read data/address with a done pulse.
// Build option: MEM_ARB_FIXED_PRIO_EN (fixed priority to requester 0
// instead of round-robin; handshake and latency unchanged).
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | waiting for an eligible request (needs mem_ready high)
// ISSUE      | mem_execute pulse, ack to the granted requester
// WAIT_BUSY  | waiting for memory to drop is_ready, bounded by a timer
// WAIT_DONE  | memory busy; waits for is_ready to return, then captures
// RESPOND    | done pulse to the granted requester
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = MEM_ADDR_WIDTH,
  parameter int DATA_W       = MEM_DATA_WIDTH,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [1:0]        req0_func,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ack,
  output logic              req0_done,
  output logic [DATA_W-1:0] req0_rdata,
  output logic [ADDR_W-1:0] req0_raddr,
  input  logic              req1_valid,
  input  logic [1:0]        req1_func,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ack,
  output logic              req1_done,
  output logic [DATA_W-1:0] req1_rdata,
  output logic [ADDR_W-1:0] req1_raddr,
  output logic [1:0]        mem_func,
  output logic              mem_execute,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [ADDR_W-1:0] mem_raddr,
  output logic              busy,
  output logic              grant_id
);

  localparam int TMR_W = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(BUSY_TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

  mem_arb_state_e   state;
  mem_arb_state_e   state_nxt;
  logic [TMR_W-1:0] busy_tmr;
  logic             rr_last;
  logic [1:0]       elig;
  logic [1:0]       pick_grant;
  logic             pick_id;
  logic             grant_take;
  logic             busy_tc;
  logic             capture;

  // Nothing is eligible while the memory is still busy with earlier work.
  assign elig = {req1_valid, req0_valid} & {2{mem_ready}};

  mem_arb_pick u_pick (
    .valid   (elig),
    .rr_last (rr_last),
    .grant   (pick_grant),
    .gnt_id  (pick_id)
  );

  assign grant_take = (state == MEM_ARB_IDLE) && (pick_grant != 2'b00);
  assign busy_tc    = (busy_tmr == TMR_ONE);
  // A timeout counts as completion: a zero-cycle memory already has its
  // result on the output bus, so it is captured just like a normal finish.
  assign capture    = ((state == MEM_ARB_WAIT_DONE) && mem_ready) ||
                      ((state == MEM_ARB_WAIT_BUSY) && mem_ready && busy_tc);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= MEM_ARB_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      MEM_ARB_IDLE:      if (grant_take) state_nxt = MEM_ARB_ISSUE;
      MEM_ARB_ISSUE:     state_nxt = MEM_ARB_WAIT_BUSY;
      MEM_ARB_WAIT_BUSY: begin
        if (!mem_ready)   state_nxt = MEM_ARB_WAIT_DONE;
        else if (busy_tc) state_nxt = MEM_ARB_RESPOND;
      end
      MEM_ARB_WAIT_DONE: if (mem_ready) state_nxt = MEM_ARB_RESPOND;
      MEM_ARB_RESPOND:   state_nxt = MEM_ARB_IDLE;
      default:           state_nxt = MEM_ARB_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state and the current owner.
  always_comb begin
    mem_execute = 1'b0;
    req0_ack    = 1'b0;
    req1_ack    = 1'b0;
    req0_done   = 1'b0;
    req1_done   = 1'b0;
    busy        = arb_busy(state);
    case (state)
      MEM_ARB_ISSUE: begin
        mem_execute = 1'b1;
        req0_ack    = ~grant_id;
        req1_ack    = grant_id;
      end
      MEM_ARB_RESPOND: begin
        req0_done = ~grant_id;
        req1_done = grant_id;
      end
      default: ;
    endcase
  end

  // Command latch, owner tracking and round-robin history.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_func  <= 2'b00;
      mem_addr  <= '0;
      mem_wdata <= '0;
      grant_id  <= 1'b0;
      rr_last   <= 1'b1;
    end else if (grant_take) begin
      grant_id <= pick_id;
      rr_last  <= pick_id;
      if (pick_id) begin
        mem_func  <= req1_func;
        mem_addr  <= req1_addr;
        mem_wdata <= req1_wdata;
      end else begin
        mem_func  <= req0_func;
        mem_addr  <= req0_addr;
        mem_wdata <= req0_wdata;
      end
    end
  end

  // Down-counter bounding how long WAIT_BUSY waits for is_ready to fall.
  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_tmr <= '0;
    end else if (state == MEM_ARB_ISSUE) begin
      busy_tmr <= TMR_LOAD;
    end else if ((state == MEM_ARB_WAIT_BUSY) && mem_ready && !busy_tc) begin
      busy_tmr <= busy_tmr - TMR_ONE;
    end
  end

  // Per-requester response capture; the other requester's copy is held.
  always_ff @(posedge clk) begin
    if (!rst) begin
      req0_rdata <= '0;
      req0_raddr <= '0;
      req1_rdata <= '0;
      req1_raddr <= '0;
    end else if (capture) begin
      if (grant_id) begin
        req1_rdata <= mem_rdata;
        req1_raddr <= mem_raddr;
      end else begin
        req0_rdata <= mem_rdata;
        req0_raddr <= mem_raddr;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small behavioural memory_unit.
// Memory model: execute seen at edge E -> is_ready falls at E+1 and stays low
// for m_lat sampled edges; m_lat==0 means it never falls (zero-cycle memory).
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int AW = MEM_ADDR_WIDTH;
  localparam int DW = MEM_DATA_WIDTH;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic [1:0]    req0_func = '0, req1_func = '0;
  logic [AW-1:0] req0_addr = '0, req1_addr = '0;
  logic [DW-1:0] req0_wdata = '0, req1_wdata = '0;
  logic          req0_ack, req1_ack, req0_done, req1_done;
  logic [DW-1:0] req0_rdata, req1_rdata;
  logic [AW-1:0] req0_raddr, req1_raddr;
  logic [1:0]    mem_func;
  logic          mem_execute;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready;
  logic [DW-1:0] mem_rdata;
  logic [AW-1:0] mem_raddr;
  logic          busy, grant_id;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BUSY_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_func(req0_func), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ack(req0_ack), .req0_done(req0_done),
    .req0_rdata(req0_rdata), .req0_raddr(req0_raddr),
    .req1_valid(req1_valid), .req1_func(req1_func), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ack(req1_ack), .req1_done(req1_done),
    .req1_rdata(req1_rdata), .req1_raddr(req1_raddr),
    .mem_func(mem_func), .mem_execute(mem_execute), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .mem_raddr(mem_raddr), .busy(busy), .grant_id(grant_id)
  );

  // memory_unit model
  logic          m_ready, m_start;
  logic          m_hold = 1'b0;
  int            m_lat = 3;
  int            m_cnt;
  logic [DW-1:0] m_data = '0;
  logic [AW-1:0] m_raddr;

  assign mem_ready = m_ready & ~m_hold;
  assign mem_rdata = m_data;
  assign mem_raddr = m_raddr;

  always @(posedge clk) begin
    if (!rst) begin
      m_ready <= 1'b1;
      m_start <= 1'b0;
      m_cnt   <= 0;
      m_raddr <= '0;
    end else begin
      if (mem_execute) begin
        m_start <= 1'b1;
        m_raddr <= mem_addr;
      end
      if (m_start) begin
        m_start <= 1'b0;
        if (m_lat > 0) begin
          m_ready <= 1'b0;
          m_cnt   <= m_lat;
        end
      end else if (!m_ready) begin
        if (m_cnt == 1) m_ready <= 1'b1;
        else            m_cnt   <= m_cnt - 1;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Issue one command and watch it; n counts edges from the sampling edge (n=1).
  task automatic do_cmd(input bit id, input logic [1:0] func, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd, output int ack_n, output int done_n,
                        output int exec_n, output int other_done);
    ack_n = -1; done_n = -1; exec_n = 0; other_done = 0;
    @(negedge clk);
    if (id) begin
      req1_valid = 1'b1; req1_func = func; req1_addr = addr; req1_wdata = wd;
    end else begin
      req0_valid = 1'b1; req0_func = func; req0_addr = addr; req0_wdata = wd;
    end
    for (int n = 1; n <= 200 && done_n < 0; n++) begin
      @(negedge clk);
      if (mem_execute) exec_n++;
      if (id ? req1_ack : req0_ack) begin
        if (ack_n < 0) ack_n = n;
        if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
      end
      if (id ? req0_done : req1_done) other_done++;
      if (id ? req1_done : req0_done) done_n = n;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  int a_n, d_n, e_n, o_n;
  int g_cnt, g_ids[4], g_own[4];
  int cnt_ack, cnt_exec, cnt_done;
  bit seen;

  initial begin
    // reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_exec", mem_execute, 0);
    chk("rst_ack0", req0_ack, 0);
    chk("rst_done1", req1_done, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_rdata0", req0_rdata, 0);
    rst = 1'b1;

    // single read: B=3 -> ack at n=1, done at n=B+4
    m_lat = 3; m_data = 68'hDEADBEEF;
    do_cmd(0, GET_CONTENTS, 16'd1, '0, a_n, d_n, e_n, o_n);
    chk("rd_ack_n", a_n, 1);
    chk("rd_done_n", d_n, 7);
    chk("rd_exec_cnt", e_n, 1);
    chk("rd_rdata0", req0_rdata, 68'hDEADBEEF);
    chk("rd_raddr0", req0_raddr, 1);
    chk("rd_rdata1", req1_rdata, 0);
    chk("rd_raddr1", req1_raddr, 0);
    chk("rd_done1_cnt", o_n, 0);
    @(negedge clk);
    chk("rd_idle_busy", busy, 0);

    // contention with both held valid
    do_reset();
    m_lat = 2; m_data = 68'h77;
    @(negedge clk);
    req0_valid = 1'b1; req0_func = GET_CONTENTS; req0_addr = 16'd10;
    req1_valid = 1'b1; req1_func = GET_CONTENTS; req1_addr = 16'd20;
    g_cnt = 0;
    for (int n = 0; n < 300 && g_cnt < 4; n++) begin
      @(negedge clk);
      if (req0_ack || req1_ack) begin
        g_ids[g_cnt] = req1_ack ? 1 : 0;
        g_own[g_cnt] = grant_id;
        chk("ct_one_ack", req0_ack & req1_ack, 0);
        g_cnt++;
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("ct_grant_count", g_cnt, 4);
    for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      chk($sformatf("ct_grant%0d", i), g_ids[i], 0);
`else
      chk($sformatf("ct_grant%0d", i), g_ids[i], i % 2);
`endif
      chk($sformatf("ct_grant_id%0d", i), g_own[i], g_ids[i]);
    end
    for (int n = 0; n < 50 && busy; n++) @(negedge clk);
    chk("ct_drain_busy", busy, 0);

    // write passthrough from requester 1
    m_lat = 2;
    do_cmd(1, SET_CONTENTS, 16'd5, 68'h123, a_n, d_n, e_n, o_n);
    chk("wr_ack_n", a_n, 1);
    chk("wr_done_n", d_n, 6);
    chk("wr_exec_cnt", e_n, 1);
    chk("wr_mem_addr", mem_addr, 5);
    chk("wr_mem_wdata", mem_wdata, 68'h123);
    chk("wr_mem_func", mem_func, SET_CONTENTS);
    chk("wr_raddr1", req1_raddr, 5);

    // memory not ready for 10 cycles
    @(negedge clk);
    m_hold = 1'b1;
    req0_valid = 1'b1; req0_func = GET_CONTENTS; req0_addr = 16'd3;
    cnt_ack = 0; cnt_exec = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (req0_ack) cnt_ack++;
      if (mem_execute) cnt_exec++;
    end
    chk("nr_ack_cnt", cnt_ack, 0);
    chk("nr_exec_cnt", cnt_exec, 0);
    chk("nr_busy", busy, 0);
    m_hold = 1'b0;
    @(negedge clk);
    chk("nr_ack_after_rise", req0_ack, 1);
    req0_valid = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk);
      if (req0_done) seen = 1'b1;
    end
    chk("nr_done_seen", seen, 1);

    // zero-cycle memory: timeout after 16 cycles in WAIT_BUSY
    m_lat = 0; m_data = 68'hABC;
    do_cmd(0, GET_CONTENTS, 16'd9, '0, a_n, d_n, e_n, o_n);
    chk("to_ack_n", a_n, 1);
    chk("to_done_n", d_n, 18);
    @(negedge clk);
    chk("to_idle_busy", busy, 0);

    // reset during WAIT_DONE
    m_lat = 8; m_data = 68'h999;
    @(negedge clk);
    req0_valid = 1'b1; req0_func = GET_NEXT; req0_addr = 16'd4; req0_wdata = 68'h4;
    seen = 1'b0;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clk);
      if (req0_ack) req0_valid = 1'b0;
      if (!mem_ready) seen = 1'b1;
    end
    chk("rm_mem_busy_seen", seen, 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rm_busy", busy, 0);
    chk("rm_exec", mem_execute, 0);
    chk("rm_done0", req0_done, 0);
    chk("rm_mem_addr", mem_addr, 0);
    chk("rm_mem_func", mem_func, 0);
    chk("rm_mem_wdata", mem_wdata, 0);
    chk("rm_rdata0", req0_rdata, 0);
    chk("rm_grant_id", grant_id, 0);
    rst = 1'b1;
    cnt_done = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (req0_done || req1_done) cnt_done++;
    end
    chk("rm_no_done", cnt_done, 0);
    m_lat = 1; m_data = 68'h55;
    do_cmd(1, GET_CONTENTS, 16'd7, '0, a_n, d_n, e_n, o_n);
    chk("rm_req1_ack_n", a_n, 1);
    chk("rm_req1_done_n", d_n, 5);
    chk("rm_rdata1", req1_rdata, 68'h55);
    chk("rm_raddr1", req1_raddr, 7);
    chk("rm_rdata0_hold", req0_rdata, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
